// File: rtl/spi_master.sv
// spi_master
//   Memory-mapped SPI master (mode 0, MSB first, 8-bit frames) on the CPU
//   register bus. Register reads are registered and return one cycle after
//   the request so the block muxes into the shared rdata path.
//
// Parameters
//   DIV_W      width of the SCLK divider register
//   DIV_RESET  divider reset value; SCLK half-period is div+1 clk cycles
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   sel    in   block select from the top-level address decode
//   addr   in   [1:0] register offset: 0 DATA, 1 STATUS, 2 DIV, 3 CS
//   re     in   read request
//   we     in   [3:0] byte write enables; only full-word writes take effect
//   wdata  in   [31:0] write data
//   rdata  out  [31:0] registered read data
//   sclk   out  SPI clock, idles low
//   mosi   out  SPI data out
//   miso   in   SPI data in
//   cs_n   out  software-controlled chip select

module spi_master #(
    parameter int          DIV_W     = 8,
    parameter int unsigned DIV_RESET = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        re,
    input  logic [3:0]  we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [DIV_W-1:0]   hcnt, hcnt_next;
    logic [2:0]         bcnt, bcnt_next;
    logic [7:0]         shreg, shreg_next;
    logic               sclk_next, mosi_next;
    logic               xfer_end;

    logic [DIV_W-1:0]   div;
    logic [7:0]         rx_byte;
    logic               done;
    logic               busy;

    logic               wr_en, rd_en, start;
    logic               unused_wdata;

    assign wr_en = sel & (&we);
    assign rd_en = sel & re;
    assign busy  = (state != IDLE);
    assign start = wr_en && (addr == 2'd0) && !busy;

    // Upper write-data bits have no register behind them.
    assign unused_wdata = ^wdata[31:8];

    // One shift register serves both directions: the transmit byte shifts
    // out of the MSB while received bits enter at the LSB on each SCLK rise,
    // so after eight rises it holds the received byte.
    always_comb begin
        state_next = state;
        hcnt_next  = hcnt;
        bcnt_next  = bcnt;
        shreg_next = shreg;
        sclk_next  = sclk;
        mosi_next  = mosi;
        xfer_end   = 1'b0;
        case (state)
            IDLE: begin
                sclk_next = 1'b0;
                if (start) begin
                    mosi_next  = wdata[7];
                    shreg_next = wdata[7:0];
                    hcnt_next  = div;
                    bcnt_next  = 3'd7;
                    state_next = LOW;
                end
            end
            LOW: begin
                if (hcnt != '0) begin
                    hcnt_next = hcnt - 1'b1;
                end else begin
                    sclk_next  = 1'b1;
                    shreg_next = {shreg[6:0], miso};
                    hcnt_next  = div;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (hcnt != '0) begin
                    hcnt_next = hcnt - 1'b1;
                end else begin
                    sclk_next = 1'b0;
                    if (bcnt == 3'd0) begin
                        xfer_end   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        // After the rise the next transmit bit sits in the MSB.
                        mosi_next  = shreg[7];
                        bcnt_next  = bcnt - 3'd1;
                        hcnt_next  = div;
                        state_next = LOW;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                sclk_next  = 1'b0;
            end
        endcase
    end

    // FSM and shift datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            hcnt  <= '0;
            bcnt  <= 3'd0;
            shreg <= 8'h00;
            sclk  <= 1'b0;
            mosi  <= 1'b0;
        end else begin
            state <= state_next;
            hcnt  <= hcnt_next;
            bcnt  <= bcnt_next;
            shreg <= shreg_next;
            sclk  <= sclk_next;
            mosi  <= mosi_next;
        end
    end

    // Software-visible registers. Transfer end outranks a same-cycle DATA
    // read so firmware never loses a completion; start and end cannot
    // coincide because they occur in different FSM states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done    <= 1'b0;
            rx_byte <= 8'h00;
            div     <= DIV_W'(DIV_RESET);
            cs_n    <= 1'b1;
        end else begin
            if (xfer_end) begin
                done    <= 1'b1;
                rx_byte <= shreg;
            end else if (start) begin
                done <= 1'b0;
            end else if (rd_en && (addr == 2'd0)) begin
                done <= 1'b0;
            end
            if (wr_en && (addr == 2'd2) && !busy) begin
                div <= wdata[DIV_W-1:0];
            end
            if (wr_en && (addr == 2'd3)) begin
                cs_n <= wdata[0];
            end
        end
    end

    // Registered read mux; rdata holds between accepted reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= 32'h0;
        end else if (rd_en) begin
            case (addr)
                2'd0:    rdata <= {24'h0, rx_byte};
                2'd1:    rdata <= {30'h0, done, busy};
                2'd2:    rdata <= {{(32-DIV_W){1'b0}}, div};
                default: rdata <= {31'h0, cs_n};
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master
//   Self-checking bench for spi_master. Expected values are pushed to a
//   scoreboard queue when stimulus is issued and popped when the DUT result
//   is observed. MISO is either looped back from MOSI or driven by a small
//   mode-0 slave model.

module tb_spi_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        re = 1'b0;
    logic [3:0]  we = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        cs_n;

    logic        loop_mode = 1'b1;
    logic        slave_load = 1'b0;
    logic [7:0]  slave_data = 8'h00;
    logic [7:0]  slave_sr;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    spi_master #(.DIV_W(8), .DIV_RESET(3)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .addr  (addr),
        .re    (re),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .sclk  (sclk),
        .mosi  (mosi),
        .miso  (miso),
        .cs_n  (cs_n)
    );

    // Mode-0 slave: presents its MSB, shifts after each SCLK fall.
    always @(posedge slave_load or negedge sclk) begin
        if (slave_load) slave_sr <= slave_data;
        else            slave_sr <= {slave_sr[6:0], 1'b0};
    end

    assign miso = loop_mode ? mosi : slave_sr[7];

    // Bus tasks are entered and left on a falling clk edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; addr = a; we = 4'hF; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 4'h0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        sel = 1'b1; re = 1'b1; addr = a;
        @(negedge clk);
        d = rdata;
        sel = 1'b0; re = 1'b0;
    endtask

    // Polls STATUS every cycle while watching SCLK/MOSI until busy drops.
    task automatic run_transfer(input int div_v, output int busy_cyc, output int pulses,
                                output int bad_high, output logic [7:0] bits, output bit timeout);
        logic prev_s;
        int   hrun;
        busy_cyc = 0; pulses = 0; bad_high = 0; bits = 8'h00; timeout = 1'b1;
        prev_s = sclk; hrun = 0;
        sel = 1'b1; re = 1'b1; addr = 2'd1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (sclk) begin
                if (!prev_s) begin
                    pulses++;
                    bits = {bits[6:0], mosi};
                end
                hrun++;
            end else begin
                if (prev_s && hrun != div_v + 1) bad_high++;
                hrun = 0;
            end
            prev_s = sclk;
            if (rdata[0]) busy_cyc++;
            else begin
                timeout = 1'b0;
                break;
            end
        end
        sel = 1'b0; re = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] got, exp;
        #2 reset = 1'b0;
        #3;
        checks++;
        if ({sclk, mosi, cs_n} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL reset_pins got sclk/mosi/cs_n=%b want 001", {sclk, mosi, cs_n});
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rdata got %h want 0", rdata);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.push_back(32'h0); exp_q.push_back(32'h3); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
        for (int i = 0; i < 4; i++) begin
            bus_read(2'(i + 1 == 4 ? 0 : i + 1), got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL reset_reg%0d got %h want %h", (i + 1) % 4, got, exp);
            end
        end
    endtask

    task automatic test_loopback;
        logic [31:0] got, exp;
        int bc, pc, bh;
        logic [7:0] bits;
        bit to;
        loop_mode = 1'b1;
        bus_write(2'd3, 32'h0);
        exp_q.push_back(32'h0);
        bus_read(2'd3, got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL lb_cs got %h want %h", got, exp); end
        bus_write(2'd0, 32'hA5);
        exp_q.push_back(32'hA5);
        run_transfer(3, bc, pc, bh, bits, to);
        checks++;
        if (to || bc != 64) begin errors++; $display("[TB] FAIL lb_busy got %0d cycles (timeout=%0d) want 64", bc, to); end
        checks++;
        if (pc != 8 || bh != 0) begin errors++; $display("[TB] FAIL lb_pulses got %0d pulses %0d bad highs want 8/0", pc, bh); end
        exp = exp_q.pop_front();
        checks++;
        if ({24'h0, bits} !== exp) begin errors++; $display("[TB] FAIL lb_mosi got %h want %h", bits, exp); end
        exp_q.push_back(32'h2); exp_q.push_back(32'hA5); exp_q.push_back(32'h0);
        bus_read(2'd1, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL lb_status_done got %h want %h", got, exp); end
        bus_read(2'd0, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL lb_data got %h want %h", got, exp); end
        bus_read(2'd1, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL lb_status_clr got %h want %h", got, exp); end
    endtask

    task automatic test_div0_slave;
        logic [31:0] got, exp;
        int bc, pc, bh;
        logic [7:0] bits;
        bit to;
        loop_mode = 1'b0;
        slave_data = 8'h3C;
        slave_load = 1'b1; #1 slave_load = 1'b0;
        @(negedge clk);
        bus_write(2'd2, 32'h0);
        bus_write(2'd0, 32'hFF);
        exp_q.push_back(32'hFF);
        run_transfer(0, bc, pc, bh, bits, to);
        checks++;
        if (to || bc != 16) begin errors++; $display("[TB] FAIL d0_busy got %0d cycles (timeout=%0d) want 16", bc, to); end
        checks++;
        if (pc != 8 || bh != 0) begin errors++; $display("[TB] FAIL d0_pulses got %0d pulses %0d bad highs want 8/0", pc, bh); end
        exp = exp_q.pop_front(); checks++;
        if ({24'h0, bits} !== exp) begin errors++; $display("[TB] FAIL d0_mosi got %h want %h", bits, exp); end
        exp_q.push_back(32'h3C);
        bus_read(2'd0, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL d0_data got %h want %h", got, exp); end
        bus_write(2'd2, 32'h3);
        loop_mode = 1'b1;
    endtask

    task automatic test_busy_ignore;
        logic [31:0] got, exp;
        int bc, pc, bh;
        logic [7:0] bits;
        bit to;
        bus_write(2'd0, 32'hC3);
        exp_q.push_back(32'hC3);
        bus_write(2'd0, 32'h00);
        bus_write(2'd2, 32'h9);
        run_transfer(3, bc, pc, bh, bits, to);
        exp = exp_q.pop_front(); checks++;
        if (to || {24'h0, bits} !== exp) begin errors++; $display("[TB] FAIL bi_mosi got %h want %h", bits, exp); end
        exp_q.push_back(32'hC3); exp_q.push_back(32'h3);
        bus_read(2'd0, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL bi_data got %h want %h", got, exp); end
        bus_read(2'd2, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL bi_div got %h want %h", got, exp); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] got, exp;
        int bc, pc, bh;
        logic [7:0] bits;
        bit to;
        bus_write(2'd0, 32'h96);
        // Land the DATA read in the final HIGH cycle of the transfer.
        repeat (63) @(negedge clk);
        exp_q.push_back(32'hC3); exp_q.push_back(32'h2);
        bus_read(2'd0, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL race_data got %h want %h", got, exp); end
        bus_read(2'd1, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL race_done got %h want %h", got, exp); end
        bus_write(2'd0, 32'h5A);
        exp_q.push_back(32'h5A);
        run_transfer(3, bc, pc, bh, bits, to);
        checks++;
        if (to || bc != 64) begin errors++; $display("[TB] FAIL b2b_busy got %0d cycles want 64", bc); end
        exp = exp_q.pop_front();
        exp_q.push_back(exp);
        bus_read(2'd0, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL b2b_data got %h want %h", got, exp); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] got, exp;
        int bc, pc, bh, rises;
        logic [7:0] bits;
        logic prev;
        bit to, found;
        bus_write(2'd0, 32'hF0);
        rises = 0; prev = sclk; found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sclk && !prev) rises++;
            prev = sclk;
            if (rises == 4) begin found = 1'b1; break; end
        end
        checks++;
        if (!found || mosi !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rm_reach got rises=%0d mosi=%b want 4 and 1", rises, mosi);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({sclk, mosi, cs_n} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL rm_async got sclk/mosi/cs_n=%b want 001", {sclk, mosi, cs_n});
        end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL rm_rdata got %h want 0", rdata); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.push_back(32'h0); exp_q.push_back(32'h3); exp_q.push_back(32'h1); exp_q.push_back(32'h0);
        bus_read(2'd1, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL rm_status got %h want %h", got, exp); end
        bus_read(2'd2, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL rm_div got %h want %h", got, exp); end
        bus_read(2'd3, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL rm_cs got %h want %h", got, exp); end
        bus_read(2'd0, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL rm_rxbyte got %h want %h", got, exp); end
        bus_write(2'd3, 32'h0);
        bus_write(2'd0, 32'h69);
        exp_q.push_back(32'h69);
        run_transfer(3, bc, pc, bh, bits, to);
        checks++;
        if (to || bc != 64 || pc != 8) begin errors++; $display("[TB] FAIL rm_next got %0d cycles %0d pulses want 64/8", bc, pc); end
        bus_read(2'd0, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("[TB] FAIL rm_data got %h want %h", got, exp); end
        bus_write(2'd3, 32'h1);
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_div0_slave();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
